// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: reads the frame-buffer base from the image-memory header,
// then streams every frame-buffer pixel in raster order through a small FIFO.
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   start             pulse to begin one frame scan (ignored while busy)
//   busy, done        scan in progress; 1-cycle pulse after the last pixel
//   mem_req, mem_gnt  image-memory port request / grant from the arbiter
//   IM_A, IM_WEN      image-memory address; IM_WEN held at 1 (read only)
//   IM_Q              read data, valid the cycle after an issued read
//   pix_data          RGB888 pixel at the FIFO head
//   pix_valid/ready   sink handshake
//   pix_sof/eol/eof   first pixel of frame / last of line / last of frame

module fb_scanout_reader #(
    parameter int unsigned FB_W       = 256,
    parameter int unsigned FB_H       = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HDR_FB_OFS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [19:0] IM_A,
    output logic        IM_WEN,
    input  logic [23:0] IM_Q,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof
);

    localparam int unsigned TOTAL = FB_W * FB_H;
    localparam int unsigned IDX_W = $clog2(TOTAL + 1);
    localparam int unsigned COL_W = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [19:0]        fb_base_q, fb_base_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COL_W-1:0]   col_q, col_d;

    // Read issued last cycle; its data is on IM_Q now.
    logic               cap_v_q, cap_v_d;
    logic [2:0]         cap_flags_q, cap_flags_d;

    logic [26:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               credit;
    logic               issue;
    logic               push;
    logic               pop;
    logic [26:0]        head;

    // The inflight read already owns a FIFO slot, so it is counted here.
    assign credit = (cnt_q + CNT_W'(cap_v_q)) < CNT_W'(FIFO_DEPTH);
    assign issue  = (state_q == S_STREAM) && mem_gnt && credit;
    assign push   = cap_v_q;
    assign pop    = pix_valid && pix_ready;

    always_comb begin
        state_d     = state_q;
        fb_base_d   = fb_base_q;
        idx_d       = idx_q;
        col_d       = col_q;
        cap_v_d     = issue;
        cap_flags_d = cap_flags_q;
        mem_req     = 1'b0;
        IM_A        = '0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                mem_req = 1'b1;
                IM_A    = 20'(HDR_FB_OFS);
                if (mem_gnt) state_d = S_HDR;
            end
            S_HDR: begin
                fb_base_d = IM_Q[19:0];
                idx_d     = '0;
                col_d     = '0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                mem_req = 1'b1;
                IM_A    = fb_base_q + 20'(idx_q);
                if (issue) begin
                    cap_flags_d = {idx_q == IDX_W'(TOTAL - 1),
                                   col_q == COL_W'(FB_W - 1),
                                   idx_q == '0};
                    idx_d = idx_q + IDX_W'(1);
                    col_d = (col_q == COL_W'(FB_W - 1)) ? '0 : col_q + COL_W'(1);
                    if (idx_q == IDX_W'(TOTAL - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!cap_v_q && cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fb_base_q   <= '0;
            idx_q       <= '0;
            col_q       <= '0;
            cap_v_q     <= 1'b0;
            cap_flags_q <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fb_base_q   <= fb_base_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            cap_v_q     <= cap_v_d;
            cap_flags_q <= cap_flags_d;
            cnt_q       <= cnt_d;
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop) rd_q <= rd_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: the count gates every output.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_q] <= {cap_flags_q, IM_Q};
    end

    assign head      = fifo_mem[rd_q];
    assign pix_valid = (cnt_q != '0);
    assign pix_data  = pix_valid ? head[23:0] : '0;
    assign pix_sof   = pix_valid & head[24];
    assign pix_eol   = pix_valid & head[25];
    assign pix_eof   = pix_valid & head[26];
    assign busy      = (state_q != S_IDLE);
    assign IM_WEN    = 1'b1;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: table vectors for the header/stream start-up,
// a queue-based frame model, and hand-written corner-case sequences.

module tb_fb_scanout_reader;

    localparam int W_A = 8;
    localparam int H_A = 4;
    localparam int N_A = W_A * H_A;
    localparam int W_B = 4;
    localparam int H_B = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, busy_a, done_a, mem_req_a, mem_gnt_a, IM_WEN_a;
    logic [19:0] IM_A_a;
    logic [23:0] IM_Q_a, pix_data_a, hdr_a;
    logic        pix_valid_a, pix_ready_a, pix_sof_a, pix_eol_a, pix_eof_a;

    logic        start_b, busy_b, done_b, mem_req_b, mem_gnt_b, IM_WEN_b;
    logic [19:0] IM_A_b;
    logic [23:0] IM_Q_b, pix_data_b, hdr_b;
    logic        pix_valid_b, pix_ready_b, pix_sof_b, pix_eol_b, pix_eof_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fb_scanout_reader #(
        .FB_W(W_A), .FB_H(H_A), .FIFO_DEPTH(4), .HDR_FB_OFS(1)
    ) u_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
        .done(done_a), .mem_req(mem_req_a), .mem_gnt(mem_gnt_a),
        .IM_A(IM_A_a), .IM_WEN(IM_WEN_a), .IM_Q(IM_Q_a),
        .pix_data(pix_data_a), .pix_valid(pix_valid_a),
        .pix_ready(pix_ready_a), .pix_sof(pix_sof_a),
        .pix_eol(pix_eol_a), .pix_eof(pix_eof_a)
    );

    fb_scanout_reader #(
        .FB_W(W_B), .FB_H(H_B), .FIFO_DEPTH(2), .HDR_FB_OFS(1)
    ) u_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
        .done(done_b), .mem_req(mem_req_b), .mem_gnt(mem_gnt_b),
        .IM_A(IM_A_b), .IM_WEN(IM_WEN_b), .IM_Q(IM_Q_b),
        .pix_data(pix_data_b), .pix_valid(pix_valid_b),
        .pix_ready(pix_ready_b), .pix_sof(pix_sof_b),
        .pix_eol(pix_eol_b), .pix_eof(pix_eof_b)
    );

    // Image memory: header word at address 1, every other word = its address.
    function automatic logic [23:0] word(input logic [19:0] a,
                                         input logic [23:0] hdr);
        return (a == 20'd1) ? hdr : {4'h0, a};
    endfunction

    always @(posedge clk) IM_Q_a <= word(IM_A_a, hdr_a);
    always @(posedge clk) IM_Q_b <= word(IM_A_b, hdr_b);

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference pixel {eof,eol,sof,rgb} for index i of a frame at base.
    function automatic logic [26:0] ref_pix(input logic [19:0] base,
                                            input int i, input int w,
                                            input int n,
                                            input logic [23:0] hdr);
        logic [19:0] a;
        a = base + 20'(i);
        return {(i == n - 1), ((i % w) == w - 1), (i == 0), word(a, hdr)};
    endfunction

    // ---------------- stimulus driver for instance A ----------------
    bit auto_drv = 0;
    int gnt_mode = 0;
    int rdy_mode = 0;
    int gnt_block = 0;
    int cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (auto_drv) begin
                if (gnt_block > 0) begin
                    mem_gnt_a = 1'b0;
                    gnt_block--;
                end else if (gnt_mode == 0) mem_gnt_a = 1'b1;
                else mem_gnt_a = ($urandom_range(0, 3) != 0);
                case (rdy_mode)
                    0: pix_ready_a = 1'b1;
                    1: pix_ready_a = ((cyc % 3) == 0);
                    default: pix_ready_a = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    // ---------------- output monitor / scoreboard for A ----------------
    logic [26:0] exp_q[$];
    logic [26:0] prev_pix;
    bit          chk_en = 0;
    bit          prev_stall = 0;
    int          ncyc = 0;
    int          hs_cnt = 0;
    int          first_hs = 0;
    int          last_hs = 0;
    int          eof_cyc = -100;
    int          done_cnt = 0;

    always @(negedge clk) begin
        logic [26:0] got;
        logic [26:0] e;
        ncyc++;
        got = {pix_eof_a, pix_eol_a, pix_sof_a, pix_data_a};
        if (done_a) begin
            done_cnt++;
            if (chk_en) check("done_timing", 64'(ncyc), 64'(eof_cyc + 1));
        end
        if (!chk_en) prev_stall = 0;
        else begin
            if (prev_stall)
                check("stall_hold", 64'({pix_valid_a, got}),
                      64'({1'b1, prev_pix}));
            if (pix_valid_a && pix_ready_a) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_pixel got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pix%0d", hs_cnt), 64'(got), 64'(e));
                end
                if (hs_cnt == 0) first_hs = ncyc;
                last_hs = ncyc;
                if (pix_eof_a) eof_cyc = ncyc;
                hs_cnt++;
            end
            prev_stall = pix_valid_a && !pix_ready_a;
            prev_pix = got;
        end
    end

    // ---------------- helper tasks ----------------
    task automatic start_frame(input logic [19:0] base);
        hdr_a = {4'h0, base};
        exp_q.delete();
        for (int i = 0; i < N_A; i++)
            exp_q.push_back(ref_pix(base, i, W_A, N_A, hdr_a));
        hs_cnt = 0;
        eof_cyc = -100;
        chk_en = 1;
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int k;
        for (k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (done_a) break;
        end
        #1;
        check("done_seen", 64'(done_a), 64'(1));
    endtask

    task automatic finish_frame(input string nm);
        int d0;
        d0 = done_cnt;
        wait_done(3000);
        check({nm, "_count"}, 64'(hs_cnt), 64'(N_A));
        check({nm, "_left"}, 64'(exp_q.size()), 64'(0));
        check({nm, "_ndone"}, 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic wait_hs(input int n);
        for (int k = 0; k < 500 && hs_cnt < n; k++) @(negedge clk);
        #1;
        check("wait_hs", 64'(hs_cnt >= n), 64'(1));
    endtask

    // ---------------- start-up vector table ----------------
    typedef struct {
        logic        start, gnt, rdy;
        logic        busy, req, valid, sof;
        logic [19:0] a;
        logic [23:0] data;
    } vec_t;

    vec_t tv[12];

    initial begin
        logic [19:0] base;
        int k, d0;
        bit seen;

        tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 20'h00000, 24'h000000};
        tv[1]  = '{1, 0, 0, 0, 0, 0, 0, 20'h00000, 24'h000000};
        tv[2]  = '{0, 0, 0, 1, 1, 0, 0, 20'h00001, 24'h000000};
        tv[3]  = '{0, 1, 0, 1, 1, 0, 0, 20'h00001, 24'h000000};
        tv[4]  = '{0, 1, 0, 1, 0, 0, 0, 20'h00000, 24'h000000};
        tv[5]  = '{0, 1, 0, 1, 1, 0, 0, 20'h00100, 24'h000000};
        tv[6]  = '{0, 0, 0, 1, 1, 0, 0, 20'h00101, 24'h000000};
        tv[7]  = '{0, 0, 0, 1, 1, 1, 1, 20'h00101, 24'h000100};
        tv[8]  = '{0, 1, 0, 1, 1, 1, 1, 20'h00101, 24'h000100};
        tv[9]  = '{0, 0, 1, 1, 1, 1, 1, 20'h00102, 24'h000100};
        tv[10] = '{0, 0, 1, 1, 1, 1, 0, 20'h00102, 24'h000101};
        tv[11] = '{0, 0, 0, 1, 1, 0, 0, 20'h00102, 24'h000000};

        reset = 1'b1;
        start_a = 0; mem_gnt_a = 0; pix_ready_a = 0; hdr_a = 24'h000100;
        start_b = 0; mem_gnt_b = 0; pix_ready_b = 0; hdr_b = 24'h000200;
        repeat (3) @(negedge clk);
        check("reset_state",
              64'({busy_a, done_a, mem_req_a, pix_valid_a, pix_sof_a,
                   pix_eol_a, pix_eof_a, IM_WEN_a, IM_A_a, pix_data_a}),
              64'({7'b0, 1'b1, 20'h0, 24'h0}));
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            start_a = tv[i].start;
            mem_gnt_a = tv[i].gnt;
            pix_ready_a = tv[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  64'({busy_a, mem_req_a, pix_valid_a, pix_sof_a,
                       IM_A_a, pix_data_a}),
                  64'({tv[i].busy, tv[i].req, tv[i].valid, tv[i].sof,
                       tv[i].a, tv[i].data}));
        end

        // Asynchronous reset mid-frame: outputs clear without a clock edge.
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("async_reset",
              64'({busy_a, done_a, mem_req_a, pix_valid_a, pix_sof_a,
                   IM_WEN_a, IM_A_a}),
              64'({5'b0, 1'b1, 20'h0}));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        auto_drv = 1;

        // Full-rate frame: one pixel per clock once streaming.
        gnt_mode = 0; rdy_mode = 0;
        start_frame(20'h01000);
        finish_frame("f1");
        check("f1_rate", 64'(last_hs - first_hs), 64'(N_A - 1));
        @(negedge clk);
        check("f1_idle", 64'({busy_a, mem_req_a}), 64'(0));

        // Sink ready one cycle in three.
        rdy_mode = 1;
        start_frame(20'h01000);
        finish_frame("f2");

        // Grant withdrawn for 10 cycles as index 10 issues.
        rdy_mode = 0;
        base = 20'h02000;
        start_frame(base);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mem_req_a && busy_a && IM_A_a == base + 20'd10) break;
        end
        gnt_block = 10;
        repeat (5) @(negedge clk);
        #1;
        check("gnt_hold_addr", 64'(IM_A_a), 64'(base + 20'd11));
        check("gnt_hold_hs", 64'(hs_cnt), 64'(11));
        finish_frame("f3");

        // Address wrap past 0xFFFFF.
        start_frame(20'hFFFF0);
        finish_frame("f4");

        // start while busy is ignored; so is start in the done cycle.
        rdy_mode = 2;
        start_frame(20'h00400);
        wait_hs(10);
        @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        finish_frame("f5");
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        check("start_on_done", 64'(busy_a), 64'(0));

        // Reset mid-frame, then a clean full frame.
        rdy_mode = 0;
        start_frame(20'h00800);
        wait_hs(20);
        d0 = done_cnt;
        reset = 1'b1;
        chk_en = 0;
        #1;
        check("reset_mid",
              64'({busy_a, done_a, mem_req_a, pix_valid_a, pix_eof_a,
                   IM_A_a}),
              64'(0));
        repeat (3) @(negedge clk);
        check("reset_nodone", 64'(done_cnt - d0), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        start_frame(20'h00800);
        finish_frame("f6");

        // Randomised grant/ready/base.
        gnt_mode = 1; rdy_mode = 2;
        for (int f = 0; f < 6; f++) begin
            base = (f % 2 == 0) ? 20'($urandom) : 20'hFFFFF - 20'($urandom_range(0, 40));
            start_frame(base);
            finish_frame($sformatf("rnd%0d", f));
        end

        // Small geometry: 4x2 frame, 2-entry FIFO.
        auto_drv = 0;
        mem_gnt_b = 1; pix_ready_b = 1;
        @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        k = 0;
        seen = 0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk);
            if (pix_valid_b && pix_ready_b) begin
                check($sformatf("small%0d", k),
                      64'({pix_eof_b, pix_eol_b, pix_sof_b, pix_data_b}),
                      64'(ref_pix(20'h00200, k, W_B, W_B * H_B, hdr_b)));
                k++;
            end
            if (done_b) seen = 1;
        end
        check("small_count", 64'(k), 64'(W_B * H_B));
        check("small_done", 64'(seen), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
